// File: rtl/madd_err_sweep_ctrl.sv
// madd_err_sweep_ctrl: exhaustive {a,b,c} sweep of an external approximate multiply-add with error metrics.
// Optional MADD_SWEEP_MSE_EN adds a registered squarer stage and the sum_sq_err output.
module madd_err_sweep_ctrl #(
  parameter int W  = 6,
  parameter int CW = 3*W+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic [W-1:0]     op_c,
  output logic             op_valid,
  input  logic [2*W-1:0]   approx_res,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CW-1:0]    vec_count,
  output logic [CW-1:0]    err_count,
  output logic [2*W-1:0]   max_abs_err,
  output logic [3*W-1:0]   max_err_vec,
  output logic [5*W:0]     sum_abs_err
`ifdef MADD_SWEEP_MSE_EN
  ,
  output logic [7*W:0]     sum_sq_err
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [3*W-1:0] cnt, s1_vec;
  logic [1:0] dcnt;
  logic [2*W-1:0] s1_app, s1_ex, exact, d;
  logic [5*W+1:0] sum_nx;
  logic s1_v, last, go, kill;
`ifdef MADD_SWEEP_MSE_EN
  localparam logic [1:0] DLAST = 2'd2;
  logic s2_v;
  logic [4*W-1:0] s2_sq, dx;
  logic [7*W+1:0] sq_nx;
`else
  localparam logic [1:0] DLAST = 2'd1;
`endif

  assign {op_a, op_b, op_c} = cnt;
  assign op_valid = (state == RUN) && !pause;
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign last = &cnt;
  assign kill = abort && busy;
  assign go = start && !abort && !busy;
  assign exact = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b} + {{W{1'b0}}, op_c};
  assign d = (s1_app >= s1_ex) ? s1_app - s1_ex : s1_ex - s1_app;
  assign sum_nx = {1'b0, sum_abs_err} + {{3*W+2{1'b0}}, d};

  always_comb begin
    state_nx = state;
    state_nx = kill ? IDLE :
               go ? RUN :
               (op_valid && last) ? DRAIN :
               (state == DRAIN && dcnt == DLAST) ? DONE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dcnt        <= '0;
      cnt         <= '0;
      aborted     <= 1'b0;
      s1_v        <= 1'b0;
      s1_app      <= '0;
      s1_ex       <= '0;
      s1_vec      <= '0;
      vec_count   <= '0;
      err_count   <= '0;
      max_abs_err <= '0;
      max_err_vec <= '0;
      sum_abs_err <= '0;
    end else begin
      state   <= state_nx;
      dcnt    <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      cnt     <= go ? '0 : (op_valid && !last) ? cnt + 1'b1 : cnt;
      aborted <= kill ? 1'b1 : go ? 1'b0 : aborted;
      s1_v    <= op_valid && !kill;
      s1_app  <= approx_res;
      s1_ex   <= exact;
      s1_vec  <= cnt;
      if (go) begin
        vec_count   <= '0;
        err_count   <= '0;
        max_abs_err <= '0;
        max_err_vec <= '0;
        sum_abs_err <= '0;
      end else if (s1_v) begin
        vec_count   <= vec_count + {{CW-1{1'b0}}, ~&vec_count};
        err_count   <= err_count + {{CW-1{1'b0}}, (d != '0) && ~&err_count};
        sum_abs_err <= sum_nx[5*W+1] ? '1 : sum_nx[5*W:0];
        if (d > max_abs_err) begin
          max_abs_err <= d;
          max_err_vec <= s1_vec;
        end
      end
    end
  end

`ifdef MADD_SWEEP_MSE_EN
  // Squaring gets its own register stage so it stays off the |d| path.
  assign dx = {{2*W{1'b0}}, d};
  assign sq_nx = {1'b0, sum_sq_err} + {{3*W+2{1'b0}}, s2_sq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v       <= 1'b0;
      s2_sq      <= '0;
      sum_sq_err <= '0;
    end else begin
      s2_v       <= s1_v && !kill;
      s2_sq      <= dx * dx;
      sum_sq_err <= go ? '0 : s2_v ? (sq_nx[7*W+1] ? '1 : sq_nx[7*W:0]) : sum_sq_err;
    end
  end
`endif
endmodule

// File: tb/tb_madd_err_sweep_ctrl.sv
// tb_madd_err_sweep_ctrl: W=3 sweeps of madd_err_sweep_ctrl against exact, zero and XOR-1 datapaths.
// Also covers abort, pause with a mid-run start, and asynchronous reset during DRAIN.
module tb_madd_err_sweep_ctrl;
  localparam int W = 3;
  localparam int CW = 3*W+1;
  localparam int NV = 1 << (3*W);
`ifdef MADD_SWEEP_MSE_EN
  localparam int DX = 1;
`else
  localparam int DX = 0;
`endif

  logic clk, rst_n, start, abort, pause, op_valid, busy, done, aborted;
  logic [W-1:0] op_a, op_b, op_c;
  logic [2*W-1:0] approx_res, ex;
  logic [CW-1:0] vec_count, err_count;
  logic [2*W-1:0] max_abs_err;
  logic [3*W-1:0] max_err_vec;
  logic [5*W:0] sum_abs_err;
`ifdef MADD_SWEEP_MSE_EN
  logic [7*W:0] sum_sq_err;
`endif
  logic [1:0] mode;
  logic [3*W-1:0] mon_next;
  int mon_n, mon_bad;
  int checks, errors;

  madd_err_sweep_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_valid(op_valid),
    .approx_res(approx_res), .busy(busy), .done(done), .aborted(aborted),
    .vec_count(vec_count), .err_count(err_count), .max_abs_err(max_abs_err),
    .max_err_vec(max_err_vec), .sum_abs_err(sum_abs_err)
`ifdef MADD_SWEEP_MSE_EN
    , .sum_sq_err(sum_sq_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: exact, tied to zero, or exact with the LSB flipped.
  always_comb begin
    ex = {3'b0, op_a} * {3'b0, op_b} + {3'b0, op_c};
    approx_res = (mode == 2'd1) ? '0 : (mode == 2'd2) ? ex ^ 6'd1 : ex;
  end

  always @(negedge clk) begin
    if (rst_n && op_valid) begin
      if ({op_a, op_b, op_c} != mon_next) mon_bad++;
      mon_next++;
      mon_n++;
    end
  end

  typedef struct {
    logic [1:0] mode;
    int vec, err, mx, mvec, sum, sq;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_next = '0;
    mon_n = 0;
    mon_bad = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 2000);
  endtask

  int n, pv_bad;

  initial begin
    checks = 0; errors = 0;
    tbl[0] = '{2'd0, NV, 0,   0,  0,     0,    0};
    tbl[1] = '{2'd1, NV, 497, 56, 'h1FF, 8064, 209664};
    tbl[2] = '{2'd2, NV, NV,  1,  0,     NV,   NV};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; mode = 2'd0;
    mon_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_op_valid", op_valid, 0);
    chk("reset_vec_count", vec_count, 0);
    chk("reset_ops", {op_a, op_b, op_c}, 0);

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      mon_clear();
      do_start();
      run_to_done(n);
      chk("sweep_done_cycle", n, NV + 3 + DX);
      chk("sweep_vec_count", vec_count, tbl[i].vec);
      chk("sweep_err_count", err_count, tbl[i].err);
      chk("sweep_max_abs_err", max_abs_err, tbl[i].mx);
      chk("sweep_max_err_vec", max_err_vec, tbl[i].mvec);
      chk("sweep_sum_abs_err", sum_abs_err, tbl[i].sum);
`ifdef MADD_SWEEP_MSE_EN
      chk("sweep_sum_sq_err", sum_sq_err, tbl[i].sq);
`endif
      chk("sweep_issue_count", mon_n, NV);
      chk("sweep_issue_order_bad", mon_bad, 0);
      chk("sweep_busy_after", busy, 0);
    end

    // Abort sampled at edge 100: vectors 0..98 have reached stage 2 by then.
    mode = 2'd0;
    do_start();
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_aborted", aborted, 1);
    chk("abort_done", done, 0);
    chk("abort_vec_count", vec_count, 99);
    repeat (5) @(negedge clk);
    chk("abort_vec_frozen", vec_count, 99);
    mon_clear();
    do_start();
    run_to_done(n);
    chk("restart_done_cycle", n, NV + 3 + DX);
    chk("restart_aborted", aborted, 0);
    chk("restart_vec_count", vec_count, NV);

    // Pause for 50 issue slots and a start pulse while RUN.
    mode = 2'd2;
    mon_clear();
    pv_bad = 0;
    do_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 200 && n <= 250 && op_valid) pv_bad++;
      if (n == 200) pause = 1'b1;
      if (n == 250) pause = 1'b0;
      if (n == 300) start = 1'b1;
      if (n == 301) start = 1'b0;
    end while (!done && n < 2000);
    chk("pause_done_cycle", n, NV + 3 + DX + 50);
    chk("pause_op_valid_bad", pv_bad, 0);
    chk("pause_vec_count", vec_count, NV);
    chk("pause_err_count", err_count, NV);
    chk("pause_issue_count", mon_n, NV);
    chk("pause_issue_order_bad", mon_bad, 0);

    // Asynchronous reset landing mid-cycle during DRAIN.
    mode = 2'd1;
    mon_clear();
    do_start();
    repeat (NV + 1) @(negedge clk);
    chk("drain_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_vec_count", vec_count, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_max_abs_err", max_abs_err, 0);
    chk("arst_sum_abs_err", sum_abs_err, 0);
    chk("arst_ops", {op_a, op_b, op_c}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_idle_done", done, 0);
    chk("arst_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
